// File: rtl/vga_rx_monitor.sv
// VGA loop-back receiver: measures line/frame timing of the incoming stream, flags lock
// once timing repeats, and captures one scaled 7x8 character cell back into a bitmap.
module vga_rx_monitor #(
    parameter int unsigned CELL_X0    = 0,
    parameter int unsigned CELL_Y0    = 0,
    parameter int unsigned CELL_SCALE = 16,
    parameter int unsigned CNT_W      = 12
) (
    input  logic             clk_vga,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank_n,
    input  logic [9:0]       vga_r,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_sync_len,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_sync_len,
    output logic [CNT_W-1:0] v_active,
    output logic [55:0]      glyph,
    output logic             frame_done,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CntOne;
    endfunction

    // Only the MSB of red carries luminance.
    logic unused_r;
    assign unused_r = ^vga_r[8:0];

    // Input stage
    logic hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, bl_s1_q, px_s1_q;
    logic hs_fall, hs_rise, vs_fall;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_q <= 1'b0;
            hs_s2_q <= 1'b0;
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            bl_s1_q <= 1'b0;
            px_s1_q <= 1'b0;
        end else begin
            hs_s1_q <= hsync;
            hs_s2_q <= hs_s1_q;
            vs_s1_q <= vsync;
            vs_s2_q <= vs_s1_q;
            bl_s1_q <= blank_n;
            px_s1_q <= vga_r[9];
        end
    end

    assign hs_fall = hs_s2_q & ~hs_s1_q;
    assign hs_rise = ~hs_s2_q & hs_s1_q;
    assign vs_fall = vs_s2_q & ~vs_s1_q;

    // Running counters and per-frame shadows
    logic [CNT_W-1:0] lc_q, lc_d, hl_q, hl_d, ax_q, ax_d;
    logic [CNT_W-1:0] ht_q, ht_d, hsl_q, hsl_d, ha_q, ha_d;
    logic [CNT_W-1:0] vt_q, vt_d, vsl_q, vsl_d, ay_q, ay_d;
    logic [55:0]      gl_q, gl_d;

    always_comb begin
        lc_d = hs_fall ? CntOne : sat_inc(lc_q);
        hl_d = hl_q;
        if (!hs_s1_q) begin
            hl_d = hs_fall ? CntOne : sat_inc(hl_q);
        end
        ax_d = hs_fall ? '0 : (bl_s1_q ? sat_inc(ax_q) : ax_q);

        // A vsync fall starts a fresh frame; events on that same cycle belong to it.
        ht_d  = vs_fall ? '0 : ht_q;
        hsl_d = vs_fall ? '0 : hsl_q;
        ha_d  = vs_fall ? '0 : ha_q;
        vt_d  = vs_fall ? '0 : vt_q;
        vsl_d = vs_fall ? '0 : vsl_q;
        ay_d  = vs_fall ? '0 : ay_q;
        gl_d  = vs_fall ? '0 : gl_q;

        if (hs_fall) begin
            ht_d = lc_q;
            vt_d = sat_inc(vt_d);
            if (!vs_s1_q) begin
                vsl_d = sat_inc(vsl_d);
            end
            if (ax_q != '0) begin
                ha_d = ax_q;
                ay_d = sat_inc(ay_d);
            end
        end
        if (hs_rise) begin
            hsl_d = hl_q;
        end

        if (bl_s1_q) begin
            for (int c = 0; c < 7; c++) begin
                for (int r = 0; r < 8; r++) begin
                    if (ax_q == CNT_W'(CELL_X0 + c * CELL_SCALE + CELL_SCALE / 2) &&
                        ay_q == CNT_W'(CELL_Y0 + r * CELL_SCALE + CELL_SCALE / 2)) begin
                        gl_d[c * 8 + r] = ~px_s1_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            lc_q  <= '0;
            hl_q  <= '0;
            ax_q  <= '0;
            ht_q  <= '0;
            hsl_q <= '0;
            ha_q  <= '0;
            vt_q  <= '0;
            vsl_q <= '0;
            ay_q  <= '0;
            gl_q  <= '0;
        end else begin
            lc_q  <= lc_d;
            hl_q  <= hl_d;
            ax_q  <= ax_d;
            ht_q  <= ht_d;
            hsl_q <= hsl_d;
            ha_q  <= ha_d;
            vt_q  <= vt_d;
            vsl_q <= vsl_d;
            ay_q  <= ay_d;
            gl_q  <= gl_d;
        end
    end

    // Frame commit and lock tracking
    logic             first_q;
    logic [1:0]       match_q, match_d;
    logic [1:0]       done_q;
    logic [CNT_W-1:0] ht_commit;
    logic             same_timing;

    always_comb begin
        // With no line edge in the frame, report the saturated line counter.
        ht_commit   = (vt_q != '0) ? ht_q : lc_q;
        same_timing = (ht_commit == h_total) && (vt_q == v_total);
        match_d     = 2'd0;
        if (same_timing) begin
            match_d = (match_q == 2'd2) ? 2'd2 : match_q + 2'd1;
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            first_q    <= 1'b0;
            match_q    <= 2'd0;
            locked     <= 1'b0;
            h_total    <= '0;
            h_sync_len <= '0;
            h_active   <= '0;
            v_total    <= '0;
            v_sync_len <= '0;
            v_active   <= '0;
            glyph      <= '0;
        end else if (vs_fall) begin
            first_q <= 1'b1;
            if (first_q) begin
                h_total    <= ht_commit;
                h_sync_len <= hsl_q;
                h_active   <= ha_q;
                v_total    <= vt_q;
                v_sync_len <= vsl_q;
                v_active   <= ay_q;
                glyph      <= gl_q;
                match_q    <= match_d;
                locked     <= (match_d == 2'd2);
            end
        end
    end

    // Pulse lands three edges after vsync is first sampled low.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 2'b00;
            frame_done <= 1'b0;
        end else begin
            done_q[0]  <= vs_fall & first_q;
            done_q[1]  <= done_q[0];
            frame_done <= done_q[1];
        end
    end

endmodule
